// File: rtl/ul_mod_seq.sv
// ul_mod_seq -- sequential remainder engine.
//
// Computes dividend mod divider for a wide unsigned dividend. It uses two
// restoring-subtract digit steps per clock and works from the MSB down. The
// block owns the dividend shift register, the partial remainder, the step
// counter and both valid/ready handshakes.
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_vld     request valid
//   in_rdy     engine can accept a request (IDLE)
//   dividend   unsigned dividend, sampled on accept
//   divider    unsigned divider, sampled on accept
//   out_vld    result valid (DONE)
//   out_rdy    consumer accepts result
//   remainder  dividend mod divider
//   err        divider was zero; qualified by out_vld
//   busy       request accepted, result not yet consumed
//
// States
//   state  | meaning
//   IDLE   | waiting for a request, in_rdy=1
//   RUN    | two remainder steps per cycle, cnt counts digit pairs left
//   DONE   | result held on remainder/err until out_rdy
module ul_mod_seq #(
  parameter int DIVIDEND_WIDTH = 32,
  parameter int DIVISOR_WIDTH  = 8,
  parameter int CNT_WIDTH      = 5
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_vld,
  output logic                      in_rdy,
  input  logic [DIVIDEND_WIDTH-1:0] dividend,
  input  logic [DIVISOR_WIDTH-1:0]  divider,
  output logic                      out_vld,
  input  logic                      out_rdy,
  output logic [DIVISOR_WIDTH-1:0]  remainder,
  output logic                      err,
  output logic                      busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(DIVIDEND_WIDTH / 2);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                    state_q, state_d;
  logic [DIVIDEND_WIDTH-1:0] sreg_q, sreg_d;
  logic [DIVISOR_WIDTH-1:0]  dreg_q, dreg_d;
  logic [DIVISOR_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d;
  logic                      err_q, err_d;

  logic [DIVISOR_WIDTH-1:0]  acc_1, acc_2;

  // One restoring step. acc < d holds on entry, so x < 2*d and a single
  // conditional subtract is enough. The sign of t is its top bit.
  function automatic logic [DIVISOR_WIDTH-1:0] rem_step(
    input logic [DIVISOR_WIDTH-1:0] acc,
    input logic                     bit_in,
    input logic [DIVISOR_WIDTH-1:0] d
  );
    logic [DIVISOR_WIDTH:0]   x;
    logic [DIVISOR_WIDTH+1:0] t;
    x = {acc, bit_in};
    t = {1'b0, x} - {2'b00, d};
    return t[DIVISOR_WIDTH+1] ? x[DIVISOR_WIDTH-1:0] : t[DIVISOR_WIDTH-1:0];
  endfunction

  assign acc_1 = rem_step(acc_q, sreg_q[DIVIDEND_WIDTH-1], dreg_q);
  assign acc_2 = rem_step(acc_1, sreg_q[DIVIDEND_WIDTH-2], dreg_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sreg_q  <= '0;
      dreg_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      dreg_q  <= dreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    dreg_d  = dreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_vld) begin
          sreg_d = dividend;
          dreg_d = divider;
          acc_d  = '0;
          cnt_d  = CNT_LOAD;
          rem_d  = '0;
          if (divider == '0) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        acc_d  = acc_2;
        sreg_d = sreg_q << 2;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          rem_d   = acc_2;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_rdy) begin
          err_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_rdy    = (state_q == S_IDLE);
  assign out_vld   = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign remainder = rem_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ul_mod_seq.sv
module tb_ul_mod_seq;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [31:0] dividend;
  logic [7:0]  divider;
  logic        out_vld;
  logic        out_rdy;
  logic [7:0]  remainder;
  logic        err;
  logic        busy;

  int passed = 0;
  int total  = 0;

  ul_mod_seq #(.DIVIDEND_WIDTH(32), .DIVISOR_WIDTH(8), .CNT_WIDTH(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .dividend(dividend), .divider(divider), .out_vld(out_vld),
    .out_rdy(out_rdy), .remainder(remainder), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  b;
    logic [7:0]  exp_rem;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Edge 1 is the edge that samples in_vld & in_rdy; lat is the edge count
  // at which out_vld is first seen high.
  task automatic do_req(input logic [31:0] a, input logic [7:0] b,
                        output logic [7:0] rem, output logic e, output int lat);
    int guard;
    guard = 0;
    while (!in_rdy && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("rdy_before_req", in_rdy, 1);
    dividend = a; divider = b; in_vld = 1'b1; out_rdy = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0; dividend = $urandom; divider = 8'($urandom);
    check("busy_after_accept", busy, 1);
    check("rdy_low_after_accept", in_rdy, 0);
    lat = 1;
    while (!out_vld && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    rem = remainder; e = err;
    @(posedge clk); #1;
    check("idle_after_consume", {in_rdy, out_vld, busy, err}, 4'b1000);
  endtask

  initial begin
    logic [7:0] rem;
    logic       e;
    int         lat;
    logic [31:0] ra;
    logic [7:0]  rb;

    rst_n = 1'b0; in_vld = 1'b0; out_rdy = 1'b0; dividend = '0; divider = '0;

    vecs[0] = '{32'd1000,       8'd7,   8'd6,   1'b0, 17};
    vecs[1] = '{32'hFFFF_FFFF,  8'd255, 8'd0,   1'b0, 17};
    // 2^32-1 = 254*16909320 + 15
    vecs[2] = '{32'hFFFF_FFFF,  8'd254, 8'd15,  1'b0, 17};
    vecs[3] = '{32'd5,          8'd200, 8'd5,   1'b0, 17};
    vecs[4] = '{32'd13,         8'd1,   8'd0,   1'b0, 17};
    vecs[5] = '{32'd123,        8'd0,   8'd0,   1'b1, 1};
    vecs[6] = '{32'd0,          8'd5,   8'd0,   1'b0, 17};
    vecs[7] = '{32'd254,        8'd255, 8'd254, 1'b0, 17};
    vecs[8] = '{32'hFFFF_FFFF,  8'd1,   8'd0,   1'b0, 17};
    vecs[9] = '{32'h8000_0000,  8'd3,   8'd2,   1'b0, 17};

    #17;
    check("reset_outputs", {in_rdy, out_vld, remainder, err, busy}, {1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      do_req(vecs[i].a, vecs[i].b, rem, e, lat);
      check($sformatf("vec%0d_rem", i), rem, vecs[i].exp_rem);
      check($sformatf("vec%0d_err", i), e, vecs[i].exp_err);
      check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
    end

    // Random requests against plain arithmetic.
    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = (i % 7 == 3) ? 8'd0 : 8'($urandom_range(1, 255));
      if (i % 5 == 1) ra = 32'($urandom_range(0, 300));
      do_req(ra, rb, rem, e, lat);
      if (rb == 0) begin
        check($sformatf("rnd%0d_rem", i), rem, 0);
        check($sformatf("rnd%0d_err", i), e, 1);
        check($sformatf("rnd%0d_lat", i), lat, 1);
      end else begin
        check($sformatf("rnd%0d_rem", i), rem, 8'(ra % 32'(rb)));
        check($sformatf("rnd%0d_err", i), e, 0);
        check($sformatf("rnd%0d_lat", i), lat, 17);
      end
    end

    // Result held while the consumer stalls; inputs are ignored meanwhile.
    out_rdy = 1'b0;
    dividend = 32'd1000; divider = 8'd7; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    lat = 1;
    while (!out_vld && lat < 100) begin
      @(posedge clk); #1; lat++;
    end
    check("hold_lat", lat, 17);
    for (int k = 0; k < 10; k++) begin
      in_vld = 1'($urandom); dividend = $urandom; divider = 8'($urandom);
      @(posedge clk); #1;
      check($sformatf("hold%0d", k), {out_vld, in_rdy, remainder, err}, {1'b1, 1'b0, 8'd6, 1'b0});
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    @(posedge clk); #1;
    check("hold_release", {in_rdy, out_vld}, 2'b10);

    do_req(32'd77, 8'd10, rem, e, lat);
    check("b2b_first_rem", rem, 7);
    do_req(32'd99, 8'd13, rem, e, lat);
    check("b2b_second_rem", rem, 8);

    // Reset in the middle of RUN.
    dividend = 32'd1000; divider = 8'd7; in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    check("busy_before_reset", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {in_rdy, out_vld, remainder, err, busy}, {1'b1, 1'b0, 8'd0, 1'b0, 1'b0});
    @(posedge clk); #1;
    check("reset_held_idle", {in_rdy, out_vld, busy}, 3'b100);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_req(32'd1000, 8'd7, rem, e, lat);
    check("post_reset_rem", rem, 6);
    check("post_reset_lat", lat, 17);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
